// File: rtl/addsub_pkg.sv
// Shared types and constants for the sequential adder/subtractor.
package addsub_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/addsub_seq_if.sv
// Start/ready/done handshake plus operand and result bundle for addsub_seq.
interface addsub_seq_if #(
  parameter int unsigned N = 8
) ();

  logic         start;
  logic         op;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         ready;
  logic         done;
  logic [N-1:0] result;
  logic         cout;
  logic         zero;
  logic         neg;
  logic         ovf;

  modport master (
    output start, op, a, b,
    input  ready, done, result, cout, zero, neg, ovf
  );

  modport slave (
    input  start, op, a, b,
    output ready, done, result, cout, zero, neg, ovf
  );

endinterface

// File: rtl/addsub_slice.sv
// Combinational W-bit ripple-carry adder; also reports the carry into its top bit.
module addsub_slice #(
  parameter int unsigned W = 2
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] s_o,
  output logic         cout_o,
  output logic         c_msb_in_o
);

  always_comb begin
    logic c;
    c          = cin_i;
    c_msb_in_o = cin_i;
    s_o        = '0;
    for (int i = 0; i < W; i++) begin
      if (i == W - 1) c_msb_in_o = c;
      s_o[i] = a_i[i] ^ b_i[i] ^ c;
      c      = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
    end
    cout_o = c;
  end

endmodule

// File: rtl/addsub_seq.sv
// Multi-cycle N-bit adder/subtractor: one CHUNK-bit slice per clock, LSB first,
// with registered result and carry/zero/negative/overflow flags.
module addsub_seq
  import addsub_pkg::*;
#(
  parameter int unsigned N     = 8,
  parameter int unsigned CHUNK = 2
) (
  input logic           clk,
  input logic           rst,
  addsub_seq_if.slave   bus_io
);

  localparam int unsigned K    = N / CHUNK;
  localparam int unsigned IdxW = (K > 1) ? $clog2(K) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(K - 1);

  if ((N < 2) || (CHUNK < 1) || (CHUNK > N) || ((N % CHUNK) != 0)) begin : g_param_check
    $error("addsub_seq: N must be >= 2 and a multiple of CHUNK, 1 <= CHUNK <= N");
  end

  state_e          state_q, state_d;
  logic [N-1:0]    a_q, a_d, b_q, b_d, sum_q, sum_d, result_q, result_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic            carry_q, carry_d;
  logic            ready_q, ready_d, done_q, done_d;
  logic            cout_q, cout_d, zero_q, zero_d, neg_q, neg_d, ovf_q, ovf_d;

  logic [CHUNK-1:0] sl_s;
  logic             sl_cout, sl_cmsb;

  // Operands shift right each RUN cycle so the active slice always sits at bit 0.
  addsub_slice #(
    .W (CHUNK)
  ) u_slice (
    .a_i        (a_q[CHUNK-1:0]),
    .b_i        (b_q[CHUNK-1:0]),
    .cin_i      (carry_q),
    .s_o        (sl_s),
    .cout_o     (sl_cout),
    .c_msb_in_o (sl_cmsb)
  );

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sum_d    = sum_q;
    idx_d    = idx_q;
    carry_d  = carry_q;
    result_d = result_q;
    cout_d   = cout_q;
    zero_d   = zero_q;
    neg_d    = neg_q;
    ovf_d    = ovf_q;
    done_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus_io.start) begin
          a_d     = bus_io.a;
          b_d     = (bus_io.op == OP_ADD) ? bus_io.b : ~bus_io.b;
          carry_d = (bus_io.op == OP_SUB);
          sum_d   = '0;
          idx_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        carry_d = sl_cout;
        // New slice enters at the top; after K shifts slice 0 lands at bit 0.
        sum_d   = (sum_q >> CHUNK) | (N'(sl_s) << (N - CHUNK));
        idx_d   = idx_q + 1'b1;
        if (idx_q == LastIdx) begin
          result_d = sum_d;
          cout_d   = sl_cout;
          zero_d   = (sum_d == '0);
          neg_d    = sum_d[N-1];
          ovf_d    = sl_cout ^ sl_cmsb;
          done_d   = 1'b1;
          state_d  = StDone;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    ready_d = (state_d == StIdle);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      sum_q    <= '0;
      idx_q    <= '0;
      carry_q  <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
      ovf_q    <= 1'b0;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sum_q    <= sum_d;
      idx_q    <= idx_d;
      carry_q  <= carry_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
      ovf_q    <= ovf_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
    end
  end

  assign bus_io.ready  = ready_q;
  assign bus_io.done   = done_q;
  assign bus_io.result = result_q;
  assign bus_io.cout   = cout_q;
  assign bus_io.zero   = zero_q;
  assign bus_io.neg    = neg_q;
  assign bus_io.ovf    = ovf_q;

endmodule

// File: tb/tb_addsub_seq.sv
// Bench for addsub_seq: four configurations run in lockstep against directed
// vectors, randomized operands with an arithmetic reference model, and reset/busy cases.
module tb_addsub_seq;
  import addsub_pkg::*;

  typedef struct packed {
    logic [15:0] res;
    logic        cout;
    logic        zero;
    logic        neg;
    logic        ovf;
  } exp_t;

  typedef struct packed {
    logic        op;
    logic        poke;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] a16;
    logic [15:0] b16;
    exp_t        e8;
    exp_t        e16;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_v [4];
  logic        op_r;
  logic [7:0]  a8_r, b8_r;
  logic [15:0] a16_r, b16_r;

  always #5 clk = ~clk;

  addsub_seq_if #(.N(8))  if0 ();
  addsub_seq_if #(.N(8))  if1 ();
  addsub_seq_if #(.N(8))  if2 ();
  addsub_seq_if #(.N(16)) if3 ();

  assign if0.start = start_v[0];
  assign if0.op    = op_r;
  assign if0.a     = a8_r;
  assign if0.b     = b8_r;
  assign if1.start = start_v[1];
  assign if1.op    = op_r;
  assign if1.a     = a8_r;
  assign if1.b     = b8_r;
  assign if2.start = start_v[2];
  assign if2.op    = op_r;
  assign if2.a     = a8_r;
  assign if2.b     = b8_r;
  assign if3.start = start_v[3];
  assign if3.op    = op_r;
  assign if3.a     = a16_r;
  assign if3.b     = b16_r;

  addsub_seq #(.N(8),  .CHUNK(2)) u_dut0 (.clk(clk), .rst(rst), .bus_io(if0));
  addsub_seq #(.N(8),  .CHUNK(1)) u_dut1 (.clk(clk), .rst(rst), .bus_io(if1));
  addsub_seq #(.N(8),  .CHUNK(8)) u_dut2 (.clk(clk), .rst(rst), .bus_io(if2));
  addsub_seq #(.N(16), .CHUNK(4)) u_dut3 (.clk(clk), .rst(rst), .bus_io(if3));

  logic        done_v [4], ready_v [4], cout_v [4], zero_v [4], neg_v [4], ovf_v [4];
  logic [15:0] res_v  [4];

  always_comb begin
    done_v[0] = if0.done;  ready_v[0] = if0.ready; res_v[0] = {8'h00, if0.result};
    cout_v[0] = if0.cout;  zero_v[0]  = if0.zero;  neg_v[0] = if0.neg; ovf_v[0] = if0.ovf;
    done_v[1] = if1.done;  ready_v[1] = if1.ready; res_v[1] = {8'h00, if1.result};
    cout_v[1] = if1.cout;  zero_v[1]  = if1.zero;  neg_v[1] = if1.neg; ovf_v[1] = if1.ovf;
    done_v[2] = if2.done;  ready_v[2] = if2.ready; res_v[2] = {8'h00, if2.result};
    cout_v[2] = if2.cout;  zero_v[2]  = if2.zero;  neg_v[2] = if2.neg; ovf_v[2] = if2.ovf;
    done_v[3] = if3.done;  ready_v[3] = if3.ready; res_v[3] = if3.result;
    cout_v[3] = if3.cout;  zero_v[3]  = if3.zero;  neg_v[3] = if3.neg; ovf_v[3] = if3.ovf;
  end

  int kk [4] = '{4, 8, 1, 4};
  int n_cmp  = 0;
  int n_fail = 0;
  vec_t vecs [9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // Reference: true signed/unsigned arithmetic, then reduce modulo 2^n.
  function automatic exp_t model(input int n, input logic op, input logic [15:0] a,
                                 input logic [15:0] b);
    exp_t   e;
    longint m, half, ua, ub, sa, sb, t, u;
    m    = longint'(1) << n;
    half = m / 2;
    ua   = longint'(a) % m;
    ub   = longint'(b) % m;
    sa   = (ua >= half) ? ua - m : ua;
    sb   = (ub >= half) ? ub - m : ub;
    t    = op ? sa - sb : sa + sb;
    u    = op ? ua - ub : ua + ub;
    e.res  = 16'(((u % m) + m) % m);
    e.cout = op ? (ua >= ub) : (u >= m);
    e.zero = (e.res == 16'h0);
    e.neg  = e.res[n-1];
    e.ovf  = (t >= half) || (t < -half);
    return e;
  endfunction

  task automatic check_cleared(input string tag);
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("%s d%0d ready", tag, d), 32'(ready_v[d]), 32'd1);
      chk($sformatf("%s d%0d done", tag, d), 32'(done_v[d]), 32'd0);
      chk($sformatf("%s d%0d result", tag, d), 32'(res_v[d]), 32'd0);
      chk($sformatf("%s d%0d flags", tag, d),
          32'({cout_v[d], zero_v[d], neg_v[d], ovf_v[d]}), 32'd0);
    end
  endtask

  task automatic run_op(input string tag, input logic op, input logic [7:0] a8,
                        input logic [7:0] b8, input logic [15:0] a16, input logic [15:0] b16,
                        input exp_t e8, input exp_t e16, input bit poke);
    int   lat  [4];
    int   dcnt [4];
    exp_t cap  [4];
    exp_t ex;
    @(negedge clk);
    op_r = op; a8_r = a8; b8_r = b8; a16_r = a16; b16_r = b16;
    for (int d = 0; d < 4; d++) begin
      start_v[d] = 1'b1; lat[d] = -1; dcnt[d] = 0; cap[d] = '0;
    end
    @(posedge clk);
    for (int j = 0; j <= 10; j++) begin
      @(negedge clk);
      for (int d = 0; d < 4; d++) begin
        if (done_v[d]) begin
          dcnt[d]++;
          if (lat[d] < 0) begin
            lat[d] = j;
            cap[d] = '{res_v[d], cout_v[d], zero_v[d], neg_v[d], ovf_v[d]};
          end
        end
        if (j <= kk[d]) chk($sformatf("%s d%0d busy ready j%0d", tag, d, j),
                            32'(ready_v[d]), 32'd0);
        else if (j == kk[d] + 1) chk($sformatf("%s d%0d ready back", tag, d),
                                     32'(ready_v[d]), 32'd1);
        start_v[d] = (poke && j <= kk[d]) ? 1'b1 : 1'b0;
      end
      if (poke) begin
        op_r = ~op; a8_r = 8'hAA; b8_r = 8'h55; a16_r = 16'hAAAA; b16_r = 16'h5555;
      end
    end
    for (int d = 0; d < 4; d++) begin
      ex = (d == 3) ? e16 : e8;
      chk($sformatf("%s d%0d latency", tag, d), 32'(lat[d]), 32'(kk[d]));
      chk($sformatf("%s d%0d done pulses", tag, d), 32'(dcnt[d]), 32'd1);
      chk($sformatf("%s d%0d result", tag, d), 32'(cap[d].res), 32'(ex.res));
      chk($sformatf("%s d%0d cout", tag, d), 32'(cap[d].cout), 32'(ex.cout));
      chk($sformatf("%s d%0d zero", tag, d), 32'(cap[d].zero), 32'(ex.zero));
      chk($sformatf("%s d%0d neg", tag, d), 32'(cap[d].neg), 32'(ex.neg));
      chk($sformatf("%s d%0d ovf", tag, d), 32'(cap[d].ovf), 32'(ex.ovf));
      chk($sformatf("%s d%0d held result", tag, d), 32'(res_v[d]), 32'(ex.res));
    end
  endtask

  initial begin
    logic        rop;
    logic [7:0]  ra, rb;
    logic [15:0] ra16, rb16;
    int          late_done [4];

    //           op      poke  a      b      a16       b16       {res,c,z,n,v} 8-bit      16-bit
    vecs[0] = '{OP_ADD, 1'b0, 8'h3C, 8'h05, 16'h003C, 16'h0005, '{16'h0041, 1'b0, 1'b0, 1'b0, 1'b0},
                '{16'h0041, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[1] = '{OP_SUB, 1'b0, 8'h05, 8'h05, 16'h0005, 16'h0005, '{16'h0000, 1'b1, 1'b1, 1'b0, 1'b0},
                '{16'h0000, 1'b1, 1'b1, 1'b0, 1'b0}};
    vecs[2] = '{OP_SUB, 1'b0, 8'h03, 8'h05, 16'h0003, 16'h0005, '{16'h00FE, 1'b0, 1'b0, 1'b1, 1'b0},
                '{16'hFFFE, 1'b0, 1'b0, 1'b1, 1'b0}};
    vecs[3] = '{OP_ADD, 1'b0, 8'h7F, 8'h01, 16'h7FFF, 16'h0001, '{16'h0080, 1'b0, 1'b0, 1'b1, 1'b1},
                '{16'h8000, 1'b0, 1'b0, 1'b1, 1'b1}};
    vecs[4] = '{OP_SUB, 1'b0, 8'h80, 8'h01, 16'h8000, 16'h0001, '{16'h007F, 1'b1, 1'b0, 1'b0, 1'b1},
                '{16'h7FFF, 1'b1, 1'b0, 1'b0, 1'b1}};
    vecs[5] = '{OP_ADD, 1'b0, 8'hFF, 8'h01, 16'hFFFF, 16'h0001, '{16'h0000, 1'b1, 1'b1, 1'b0, 1'b0},
                '{16'h0000, 1'b1, 1'b1, 1'b0, 1'b0}};
    vecs[6] = '{OP_ADD, 1'b1, 8'h10, 8'h20, 16'h0010, 16'h0020, '{16'h0030, 1'b0, 1'b0, 1'b0, 1'b0},
                '{16'h0030, 1'b0, 1'b0, 1'b0, 1'b0}};
    vecs[7] = '{OP_SUB, 1'b0, 8'h00, 8'h01, 16'h0000, 16'h0001, '{16'h00FF, 1'b0, 1'b0, 1'b1, 1'b0},
                '{16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0}};
    vecs[8] = '{OP_ADD, 1'b0, 8'h80, 8'h80, 16'h8000, 16'h8000, '{16'h0000, 1'b1, 1'b1, 1'b0, 1'b1},
                '{16'h0000, 1'b1, 1'b1, 1'b0, 1'b1}};

    rst = 1'b1;
    op_r = 1'b0; a8_r = '0; b8_r = '0; a16_r = '0; b16_r = '0;
    for (int d = 0; d < 4; d++) start_v[d] = 1'b0;
    repeat (3) @(negedge clk);
    check_cleared("reset");
    rst = 1'b0;

    for (int i = 0; i < 9; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].a16,
             vecs[i].b16, vecs[i].e8, vecs[i].e16, vecs[i].poke);
    end

    for (int i = 0; i < 40; i++) begin
      rop  = 1'($urandom);
      ra   = 8'($urandom);
      rb   = 8'($urandom);
      ra16 = 16'($urandom);
      rb16 = 16'($urandom);
      run_op($sformatf("rnd%0d", i), rop, ra, rb, ra16, rb16,
             model(8, rop, {8'h00, ra}, {8'h00, rb}), model(16, rop, ra16, rb16),
             bit'($urandom_range(0, 3) == 0));
    end

    // Reset lands on the second RUN edge; the in-flight op must vanish.
    @(negedge clk);
    op_r = OP_ADD; a8_r = 8'h3C; b8_r = 8'h05; a16_r = 16'h003C; b16_r = 16'h0005;
    for (int d = 0; d < 4; d++) start_v[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 4; d++) start_v[d] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_cleared("midreset");
    rst = 1'b0;
    for (int d = 0; d < 4; d++) late_done[d] = 0;
    repeat (12) begin
      @(negedge clk);
      for (int d = 0; d < 4; d++) if (done_v[d]) late_done[d]++;
    end
    for (int d = 0; d < 4; d++)
      chk($sformatf("midreset d%0d stray done", d), 32'(late_done[d]), 32'd0);

    run_op("postreset", vecs[0].op, vecs[0].a, vecs[0].b, vecs[0].a16, vecs[0].b16,
           vecs[0].e8, vecs[0].e16, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
